frame_stream_source: RTL and testbench
======================================

Name: frame_stream_source

Overview:
Transmitter side of the pixel-stream interface consumed by the stride-2 line buffer controller. On a start pulse it reads one input_y x input_y frame from a synchronous-read feature-map memory in raster order. It drives pixel data with input_valid, sof and eof, aligned exactly as the line buffer control expects. It supports stall via pause and back-to-back frames with no gap cycle.

Parameters:
input_y, 6, frame width and height in pixels (square frame); supported range 1..45
DATA_W, 8, pixel width in bits
ADDR_W, 11, memory address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  frame request, sampled every clock
pause  input  1  stall; no memory read is issued in a cycle with pause=1
frame_base  input  ADDR_W  address of pixel (0,0); sampled when a start is accepted
mem_rd_en  output  1  memory read strobe
mem_addr  output  ADDR_W  memory read address
mem_rdata  input  DATA_W  read data, valid one cycle after mem_rd_en
pixel_out  output  DATA_W  combinational pass-through of mem_rdata
input_valid  output  1  pixel_out valid this cycle
sof  output  1  first pixel of frame; only asserted together with input_valid
eof  output  1  last pixel of frame; only asserted together with input_valid
done  output  1  one-cycle pulse, coincident with eof
busy  output  1  high from start acceptance through the eof cycle
x_count  output  11  column of the next read (debug)
y_count  output  11  row of the next read (debug)

Behaviour:
- Reset (rst=0, async): state=S_IDLE. mem_rd_en, input_valid, sof, eof, done and busy are 0. mem_addr, x_count and y_count are 0.
- States: S_IDLE and S_RUN.
- S_IDLE:
  - start=1 at an edge: latch frame_base into the address counter, set x=y=0, busy<=1, go to S_RUN.
  - start is not otherwise acted on.
- S_RUN, issue stage (registered outputs):
  - Each cycle with pause=0: mem_rd_en=1, mem_addr=current address. Then the address increments by 1, x increments, and x wraps to 0 after input_y-1 with y incrementing.
  - Each cycle with pause=1: mem_rd_en=0 and the counters hold.
  - Pause affects only the issue stage. A read already issued still produces its output.
- Output stage, one register delay after the issue stage:
  - input_valid(t+1) = mem_rd_en(t).
  - sof(t+1) = mem_rd_en(t) AND read was pixel (0,0).
  - eof(t+1) = done(t+1) = mem_rd_en(t) AND read was pixel (input_y-1, input_y-1).
- Last-pixel issue cycle:
  - If start=1 in that cycle: reload from frame_base and stay in S_RUN. The next frame's first read issues on the following non-paused cycle, so the output can show eof then sof on consecutive cycles. busy stays 1.
  - Otherwise: go to S_IDLE. busy drops to 0 the cycle after eof.
- start while in S_RUN, other than on the last-pixel issue cycle, is ignored: no restart and no queuing.
- Latency: start accepted at edge E0 gives the first mem_rd_en in cycle E0+1 and input_valid/sof in cycle E0+2.
- Total valid pixels per frame = input_y*input_y, independent of pause.
- mem_addr wraps modulo 2^ADDR_W with no error flag.
- input_y=1: sof, eof and done are all asserted on the single valid cycle.
- x_count and y_count are 11-bit; they hold their final values in S_IDLE until the next start.
- Reset mid-frame: the output pipeline is flushed with no partial eof. The next start begins a fresh frame with sof.

Test Plan:
- input_y=6, frame_base=100, start pulse at cycle 0, pause=0:
  - mem_rd_en in cycles 1..36 with mem_addr 100..135.
  - input_valid in cycles 2..37; sof only at cycle 2; eof=done only at cycle 37.
  - busy=0 from cycle 38.
- Same frame with pause=1 in cycles 5, 6 and 20:
  - exactly 36 valid cycles, no mem_rd_en in the paused cycles, valid gaps at cycles 6, 7 and 21.
  - addresses contiguous; eof at cycle 40.
- Back-to-back: start held high during issue cycle 36, frame_base=200:
  - eof at cycle 37, then sof at cycle 38 with the address-200 pixel.
  - busy stays 1 throughout; 72 valid cycles in total.
- Start pulses at cycles 10 and 20 mid-frame: no effect; the output is identical to the first scenario.
- rst asserted asynchronously mid-cycle at cycle 15:
  - all outputs 0 immediately.
  - start released later produces sof two cycles after acceptance and a full 36-pixel frame.
- input_y=1: start gives exactly one valid cycle with sof=eof=done=1 at acceptance+2.

Source files
------------

// File: rtl/frame_stream_source_if.sv
// Memory read port and pixel stream of the frame source, bundled as one interface.
// master = frame source side, slave = memory / line-buffer side.
interface frame_stream_source_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pixel_out;
  logic              input_valid;
  logic              sof;
  logic              eof;

  modport master (
    output mem_rd_en, mem_addr, pixel_out, input_valid, sof, eof,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd_en, mem_addr, pixel_out, input_valid, sof, eof,
    output mem_rdata
  );
endinterface

// File: rtl/frame_stream_source.sv
// Reads an input_y x input_y frame in raster order from a synchronous-read memory
// and presents it as a pixel stream with sof/eof framing, pause stall and back-to-back frames.
module frame_stream_source #(
  parameter int input_y = 6,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic [ADDR_W-1:0]     frame_base,
  frame_stream_source_if.master bus,
  output logic                  done,
  output logic                  busy,
  output logic [10:0]           x_count,
  output logic [10:0]           y_count
);

  localparam logic [10:0] LAST = 11'(input_y - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [10:0]       x, y, x_nx, y_nx;
  logic              issue, first_px, last_px;
  logic              valid_q, sof_q, eof_q;
  logic [DATA_W-1:0] pix;

  always_comb begin
    issue    = (state == S_RUN) && !pause;
    first_px = (x == '0) && (y == '0);
    last_px  = (x == LAST) && (y == LAST);
    state_nx = state;
    addr_nx  = addr;
    x_nx     = x;
    y_nx     = y;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RUN;
          addr_nx  = frame_base;
          x_nx     = '0;
          y_nx     = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          // A start on the last-pixel issue cycle chains the next frame with no gap.
          if (last_px && start) begin
            addr_nx = frame_base;
            x_nx    = '0;
            y_nx    = '0;
          end else begin
            addr_nx = addr + 1'b1;
            if (x == LAST) begin
              x_nx = '0;
              y_nx = y + 1'b1;
            end else begin
              x_nx = x + 1'b1;
            end
            if (last_px) state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr    <= '0;
      x       <= '0;
      y       <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      x       <= x_nx;
      y       <= y_nx;
      // Read data returns one cycle after the strobe, so the framing tags follow by one register.
      valid_q <= issue;
      sof_q   <= issue && first_px;
      eof_q   <= issue && last_px;
    end
  end

  assign pix             = bus.mem_rdata;
  assign bus.pixel_out   = pix;
  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = addr;
  assign bus.input_valid = valid_q;
  assign bus.sof         = sof_q;
  assign bus.eof         = eof_q;
  assign done            = eof_q;
  // The eof beat is still in flight after the FSM has returned to idle.
  assign busy            = (state == S_RUN) || valid_q;
  assign x_count         = x;
  assign y_count         = y;

endmodule

// File: tb/tb_frame_stream_source.sv
// Directed bench for frame_stream_source: a pixel-index model checks every cycle,
// and per-scenario literal expectations pin the model.
module tb_frame_stream_source;

  logic        clk, rst, start, pause;
  logic [10:0] frame_base;
  logic        done0, busy0, done1, busy1;
  logic [10:0] x0, y0, x1, y1;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  frame_stream_source_if #(.DATA_W(8), .ADDR_W(11)) b0 ();
  frame_stream_source_if #(.DATA_W(8), .ADDR_W(11)) b1 ();

  frame_stream_source #(.input_y(6), .DATA_W(8), .ADDR_W(11)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .frame_base(frame_base),
    .bus(b0), .done(done0), .busy(busy0), .x_count(x0), .y_count(y0)
  );

  frame_stream_source #(.input_y(1), .DATA_W(8), .ADDR_W(11)) dut1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .frame_base(frame_base),
    .bus(b1), .done(done1), .busy(busy1), .x_count(x1), .y_count(y1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix(input logic [10:0] a);
    return 8'(a * 7 + 3);
  endfunction

  // Synchronous-read memories
  always @(posedge clk) begin
    if (b0.mem_rd_en) b0.mem_rdata <= pix(b0.mem_addr);
    if (b1.mem_rd_en) b1.mem_rdata <= pix(b1.mem_addr);
  end

  // Model: each frame is a linear pixel index k; x/y/address derive arithmetically.
  int          nn[2]    = '{6, 1};
  bit          act[2]   = '{0, 0};
  int          k[2]     = '{0, 0};
  bit          pv[2]    = '{0, 0};
  int          pk[2]    = '{0, 0};
  logic [10:0] mbase[2] = '{11'd0, 11'd0};
  logic [10:0] paddr[2] = '{11'd0, 11'd0};

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        act[i] <= 1'b0; k[i] <= 0; pv[i] <= 1'b0; pk[i] <= 0;
        mbase[i] <= '0; paddr[i] <= '0;
      end else begin
        pv[i]    <= act[i] && !pause;
        pk[i]    <= k[i];
        paddr[i] <= mbase[i] + 11'(k[i]);
        if (act[i]) begin
          if (!pause) begin
            if (k[i] == nn[i] * nn[i] - 1 && start) begin
              mbase[i] <= frame_base;
              k[i]     <= 0;
            end else begin
              k[i] <= k[i] + 1;
              if (k[i] == nn[i] * nn[i] - 1) act[i] <= 1'b0;
            end
          end
        end else if (start) begin
          act[i]   <= 1'b1;
          mbase[i] <= frame_base;
          k[i]     <= 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  task automatic check_dut(input int i, input logic rd, input logic [10:0] addr,
                           input logic [7:0] px, input logic v, input logic s,
                           input logic e, input logic d, input logic b,
                           input logic [10:0] xc, input logic [10:0] yc);
    int          n    = nn[i];
    int          last = n * n - 1;
    logic [10:0] ea   = mbase[i] + 11'(k[i]);
    string       p    = (i == 0) ? "n6" : "n1";
    chk({p, "_rd_en"}, 32'(rd), 32'(act[i] && !pause));
    chk({p, "_addr"},  32'(addr), 32'(ea));
    chk({p, "_valid"}, 32'(v), 32'(pv[i]));
    chk({p, "_sof"},   32'(s), 32'(pv[i] && pk[i] == 0));
    chk({p, "_eof"},   32'(e), 32'(pv[i] && pk[i] == last));
    chk({p, "_done"},  32'(d), 32'(pv[i] && pk[i] == last));
    chk({p, "_busy"},  32'(b), 32'(act[i] || pv[i]));
    chk({p, "_x"},     32'(xc), 32'(k[i] % n));
    chk({p, "_y"},     32'(yc), 32'(k[i] / n));
    if (pv[i]) chk({p, "_pixel"}, 32'(px), 32'(pix(paddr[i])));
  endtask

  always @(negedge clk) begin
    check_dut(0, b0.mem_rd_en, b0.mem_addr, b0.pixel_out, b0.input_valid, b0.sof,
              b0.eof, done0, busy0, x0, y0);
    check_dut(1, b1.mem_rd_en, b1.mem_addr, b1.pixel_out, b1.input_valid, b1.sof,
              b1.eof, done1, busy1, x1, y1);
  end

  // Stimulus vectors and per-scenario observations of the DUTs
  bit          st_v[0:99];
  bit          pa_v[0:99];
  logic [10:0] fb_v[0:99];
  bit          obs_v[0:99];
  bit          obs_rd[0:99];
  logic [10:0] obs_addr[0:99];
  logic [7:0]  obs_pix[0:99];
  int n_valid, sof_c, sof_last, sof_n, eof_c, eof_n, done_n, rd_in_pause, busy_low;
  int n_valid1, sof1_c, sof1_n, eof1_n, done1_n;

  task automatic clear_vec();
    for (int i = 0; i < 100; i++) begin
      st_v[i] = 1'b0; pa_v[i] = 1'b0; fb_v[i] = 11'd100;
    end
  endtask

  task automatic reset_checks();
    chk("rst_rd_en", 32'(b0.mem_rd_en), 0);
    chk("rst_valid", 32'(b0.input_valid), 0);
    chk("rst_sof",   32'(b0.sof), 0);
    chk("rst_eof",   32'(b0.eof), 0);
    chk("rst_done",  32'(done0), 0);
    chk("rst_busy",  32'(busy0), 0);
    chk("rst_addr",  32'(b0.mem_addr), 0);
    chk("rst_x",     32'(x0), 0);
    chk("rst_y",     32'(y0), 0);
  endtask

  task automatic run(input int ncyc, input int rst_at, input int rst_rel);
    n_valid = 0; sof_c = -1; sof_last = -1; sof_n = 0; eof_c = -1; eof_n = 0;
    done_n = 0; rd_in_pause = 0; busy_low = -1;
    n_valid1 = 0; sof1_c = -1; sof1_n = 0; eof1_n = 0; done1_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == rst_rel) rst = 1'b1;
      start      = st_v[c];
      pause      = pa_v[c];
      frame_base = fb_v[c];
      if (c == rst_at) begin
        #2 rst = 1'b0;
        #1 reset_checks();
      end
      @(negedge clk);
      obs_v[c]    = b0.input_valid;
      obs_rd[c]   = b0.mem_rd_en;
      obs_addr[c] = b0.mem_addr;
      obs_pix[c]  = b0.pixel_out;
      if (b0.input_valid) n_valid++;
      if (b0.sof) begin
        if (sof_c < 0) sof_c = c;
        sof_last = c;
        sof_n++;
      end
      if (b0.eof) begin
        if (eof_c < 0) eof_c = c;
        eof_n++;
      end
      if (done0) done_n++;
      if (pause && b0.mem_rd_en) rd_in_pause++;
      if (!busy0 && busy_low < 0 && c > 0) busy_low = c;
      if (b1.input_valid) n_valid1++;
      if (b1.sof) begin
        if (sof1_c < 0) sof1_c = c;
        sof1_n++;
      end
      if (b1.eof) eof1_n++;
      if (done1) done1_n++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    pause = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0; frame_base = '0;
    repeat (3) @(posedge clk);
    #1 reset_checks();
    rst = 1'b1;

    // Plain frame, base 100
    clear_vec(); st_v[0] = 1'b1;
    run(40, -1, -1);
    chk("s1_sof_cycle", sof_c, 2);
    chk("s1_eof_cycle", eof_c, 37);
    chk("s1_valid_cnt", n_valid, 36);
    chk("s1_sof_cnt", sof_n, 1);
    chk("s1_done_cnt", done_n, 1);
    chk("s1_busy_low", busy_low, 38);
    chk("s1_addr_c1", 32'(obs_addr[1]), 100);
    chk("s1_addr_c36", 32'(obs_addr[36]), 135);
    chk("s1_rd_c37", 32'(obs_rd[37]), 0);
    chk("s1_pix_c2", 32'(obs_pix[2]), 191);
    chk("s1_n1_valid_cnt", n_valid1, 1);
    chk("s1_n1_sof_cycle", sof1_c, 2);
    chk("s1_n1_eof_cnt", eof1_n, 1);
    chk("s1_n1_done_cnt", done1_n, 1);

    // Pause in cycles 5, 6, 20
    clear_vec(); st_v[0] = 1'b1; pa_v[5] = 1'b1; pa_v[6] = 1'b1; pa_v[20] = 1'b1;
    run(44, -1, -1);
    chk("s2_valid_cnt", n_valid, 36);
    chk("s2_eof_cycle", eof_c, 40);
    chk("s2_rd_in_pause", rd_in_pause, 0);
    chk("s2_gap_c6", 32'(obs_v[6]), 0);
    chk("s2_gap_c7", 32'(obs_v[7]), 0);
    chk("s2_gap_c21", 32'(obs_v[21]), 0);
    chk("s2_addr_c7", 32'(obs_addr[7]), 104);
    chk("s2_busy_low", busy_low, 41);

    // Back-to-back, second frame at base 200
    clear_vec(); st_v[0] = 1'b1; st_v[36] = 1'b1;
    for (int i = 36; i < 100; i++) fb_v[i] = 11'd200;
    run(76, -1, -1);
    chk("s3_eof_first", eof_c, 37);
    chk("s3_sof_second", sof_last, 38);
    chk("s3_sof_cnt", sof_n, 2);
    chk("s3_eof_cnt", eof_n, 2);
    chk("s3_valid_cnt", n_valid, 72);
    chk("s3_addr_c37", 32'(obs_addr[37]), 200);
    chk("s3_pix_c38", 32'(obs_pix[38]), 123);
    chk("s3_busy_low", busy_low, 74);

    // Mid-frame starts are ignored
    clear_vec(); st_v[0] = 1'b1; st_v[10] = 1'b1; st_v[20] = 1'b1;
    run(40, -1, -1);
    chk("s4_sof_cnt", sof_n, 1);
    chk("s4_eof_cycle", eof_c, 37);
    chk("s4_valid_cnt", n_valid, 36);
    chk("s4_busy_low", busy_low, 38);

    // Asynchronous reset at cycle 15, restart at cycle 20
    clear_vec(); st_v[0] = 1'b1; st_v[20] = 1'b1;
    run(60, 15, 18);
    chk("s5_eof_cnt", eof_n, 1);
    chk("s5_eof_cycle", eof_c, 57);
    chk("s5_sof_cnt", sof_n, 2);
    chk("s5_sof_restart", sof_last, 22);
    chk("s5_valid_cnt", n_valid, 49);
    chk("s5_busy_low", busy_low, 15);

    // Start held for three cycles: 1x1 frames chain, 6x6 ignores the extras
    clear_vec(); st_v[0] = 1'b1; st_v[1] = 1'b1; st_v[2] = 1'b1;
    run(42, -1, -1);
    chk("s6_n1_valid_cnt", n_valid1, 3);
    chk("s6_n1_sof_cnt", sof1_n, 3);
    chk("s6_n1_eof_cnt", eof1_n, 3);
    chk("s6_n1_sof_first", sof1_c, 2);
    chk("s6_valid_cnt", n_valid, 36);
    chk("s6_sof_cnt", sof_n, 1);

    // Address wraps modulo 2^11
    clear_vec(); st_v[0] = 1'b1;
    for (int i = 0; i < 100; i++) fb_v[i] = 11'd2040;
    run(40, -1, -1);
    chk("s7_addr_c1", 32'(obs_addr[1]), 2040);
    chk("s7_addr_c9", 32'(obs_addr[9]), 0);
    chk("s7_valid_cnt", n_valid, 36);
    chk("s7_eof_cycle", eof_c, 37);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
